// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, reads imem combinationally, queues {pc, instr} for decode.
// Latency: a pushed word is at the FIFO head right after its edge; redirect costs one empty cycle.
// Backpressure: if_ready=0 fills the queue, then the PC freezes; push and pop may share a cycle when full.

module inst_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_vld,
    output logic [W-1:0]               head_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            // Pointers only need to agree; the contents become don't-care.
            cnt_d    = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign count    = cnt_q;
    assign head_vld = (cnt_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
endmodule

module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_BYTES  = 32,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err,
    output logic [31:0] retire_cnt
);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] PC_MASK = 32'(MEM_BYTES - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic          misalign_q, misalign_d;
    logic [31:0]   retire_q, retire_d;
    logic [CW-1:0] fifo_cnt;
    logic          head_vld;
    logic [63:0]   head_dat;
    logic          pop, push;

    assign pop  = head_vld && if_ready;
    assign push = fetch_en && !redirect_valid && ((fifo_cnt < DEPTH_C) || pop);

    inst_fetch_fifo #(
        .W     (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .push_dat ({pc_q, imem_instr}),
        .pop      (pop),
        .count    (fifo_cnt),
        .head_vld (head_vld),
        .head_dat (head_dat)
    );

    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        retire_d   = retire_q + {31'b0, pop};
        if (redirect_valid) begin
            // Low bits are dropped for the fetch address but still flagged.
            pc_d = {redirect_pc[31:2], 2'b00} & PC_MASK;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (push) begin
            pc_d = (pc_q + 32'd4) & PC_MASK;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            retire_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            retire_q   <= retire_d;
        end
    end

    assign imem_pc      = pc_q;
    assign if_valid     = head_vld;
    assign if_pc        = head_vld ? head_dat[63:32] : 32'h0;
    assign if_instr     = head_vld ? head_dat[31:0] : 32'h0;
    assign misalign_err = misalign_q;
    assign retire_cnt   = retire_q;
endmodule
